// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU memory-port initiator.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [7:0] size_mask(input lsu_size_t s);
    logic [7:0] m;
    case (s)
      SZ_B:    m = MASK_B;
      SZ_H:    m = MASK_H;
      SZ_W:    m = MASK_W;
      default: m = MASK_D;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] size_bytes(input lsu_size_t s);
    logic [3:0] n;
    case (s)
      SZ_B:    n = 4'd1;
      SZ_H:    n = 4'd2;
      SZ_W:    n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the low 1/2/4/8 bytes of a read beat and zero- or sign-extends them.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] raw,
  input  lsu_size_t   size,
  input  logic        is_signed,
  output logic [63:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_B:    data = {{56{is_signed & raw[7]}},  raw[7:0]};
      SZ_H:    data = {{48{is_signed & raw[15]}}, raw[15:0]};
      SZ_W:    data = {{32{is_signed & raw[31]}}, raw[31:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator for the simulation memory port.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter logic [63:0] BASE             = 64'h8000_0000,
  parameter logic [63:0] SIZE             = 64'h0800_0000,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd_en,
  output logic [63:0] mem_rd_addr,
  input  logic [63:0] mem_rd_data,
  output logic        mem_we_en,
  output logic [63:0] mem_we_addr,
  output logic [63:0] mem_we_data,
  output logic [7:0]  mem_we_mask
);

  lsu_state_t  state, state_n;
  lsu_size_t   req_sz, size_q;
  logic        wen_q, sgn_q, err_q;
  logic [63:0] addr_q, wdata_q, rdata_q, aligned;

  logic [3:0]  nbytes;
  logic [64:0] first, last, limit;
  logic        misalign, fault;

  assign req_sz = lsu_size_t'(req_size);

  // Range check in 65 bits so an access running past 2^64 cannot wrap into the window.
  always_comb begin
    nbytes   = size_bytes(req_sz);
    first    = {1'b0, req_addr};
    last     = first + {61'd0, nbytes} - 65'd1;
    limit    = {1'b0, BASE} + {1'b0, SIZE};
    misalign = (req_addr[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0;
    fault    = (first < {1'b0, BASE}) || (last >= limit) ||
               ((ALLOW_MISALIGNED == 1'b0) && misalign);
  end

  lsu_load_align u_align (
    .raw       (mem_rd_data),
    .size      (size_q),
    .is_signed (sgn_q),
    .data      (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wen_q   <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        wen_q   <= req_wen;
        sgn_q   <= req_signed;
        size_q  <= req_sz;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= fault;
        rdata_q <= '0;
      end
      if (state == WAIT) begin
        rdata_q <= aligned;
      end
    end
  end

  always_comb begin
    state_n     = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_we_en   = 1'b0;
    mem_we_addr = '0;
    mem_we_data = '0;
    mem_we_mask = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = fault ? RESP : ISSUE;
      end
      ISSUE: begin
        if (wen_q) begin
          mem_we_en   = 1'b1;
          mem_we_addr = addr_q;
          mem_we_data = wdata_q;
          mem_we_mask = size_mask(size_q);
          state_n     = RESP;
        end else begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = addr_q;
          state_n     = WAIT;
        end
      end
      WAIT: state_n = RESP;
      default: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: vector table plus corner-case sequences.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_rd_en, mem_we_en;
  logic [63:0] mem_rd_addr, mem_rd_data, mem_we_addr, mem_we_data;
  logic [7:0]  mem_we_mask;
  logic [63:0] rd_pattern;

  logic        valid2, req_ready2, resp_valid2, resp_err2, rd_en2, we_en2;
  logic [63:0] resp_rdata2, rd_addr2, we_addr2, we_data2;
  logic [7:0]  we_mask2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] pat;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  always #5 clk = ~clk;

  lsu_mem_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_we_en(mem_we_en), .mem_we_addr(mem_we_addr), .mem_we_data(mem_we_data),
    .mem_we_mask(mem_we_mask)
  );

  lsu_mem_master #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .rst(rst),
    .req_valid(valid2), .req_ready(req_ready2), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed),
    .resp_valid(resp_valid2), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .mem_rd_en(rd_en2), .mem_rd_addr(rd_addr2), .mem_rd_data(mem_rd_data),
    .mem_we_en(we_en2), .mem_we_addr(we_addr2), .mem_we_data(we_data2),
    .mem_we_mask(we_mask2)
  );

  // Memory model: read beat appears the cycle after the strobe, junk otherwise.
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? rd_pattern : 64'h5A5A_5A5A_5A5A_5A5A;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_mask(input logic [1:0] s);
    case (s)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] outs_or();
    return resp_rdata | mem_rd_addr | mem_we_addr | mem_we_data |
           {56'd0, mem_we_mask} |
           {60'd0, resp_valid, resp_err, mem_rd_en, mem_we_en};
  endfunction

  task automatic do_req(input vec_t v);
    int   lat = 0;
    int   we_cnt = 0;
    int   rd_cnt = 0;
    exp_t e;
    @(negedge clk);
    req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_signed = v.sgn; rd_pattern = v.pat;
    req_valid = 1'b1; resp_ready = 1'b1;
    chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    sb.push_back('{v.exp_rdata, v.exp_err});
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (mem_we_en) begin
        we_cnt++;
        chk("we_addr", mem_we_addr, v.addr);
        chk("we_data", mem_we_data, v.wdata);
        chk("we_mask", {56'd0, mem_we_mask}, {56'd0, exp_mask(v.size)});
      end
      if (mem_rd_en) begin
        rd_cnt++;
        chk("rd_addr", mem_rd_addr, v.addr);
      end
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, v.exp_lat);
    if (resp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_rdata", resp_rdata, e.rdata);
      chk("resp_err", resp_err, e.err);
    end
    chk("we_strobes", we_cnt, (!v.exp_err && v.wen) ? 1 : 0);
    chk("rd_strobes", rd_cnt, (!v.exp_err && !v.wen) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   seen;
    vecs[0]  = '{1'b1, 64'h8000_0008, 64'h1122334455667788, 2'd3, 1'b0, 64'h0, 64'h0, 1'b0, 2};
    vecs[1]  = '{1'b0, 64'h8000_0003, 64'h0, 2'd0, 1'b1, 64'h0123456789ABCD80, 64'hFFFFFFFFFFFFFF80, 1'b0, 3};
    vecs[2]  = '{1'b0, 64'h8000_0003, 64'h0, 2'd0, 1'b0, 64'h0123456789ABCD80, 64'h80, 1'b0, 3};
    vecs[3]  = '{1'b0, 64'h8000_0020, 64'h0, 2'd2, 1'b0, 64'hDEADBEEFCAFEF00D, 64'h00000000CAFEF00D, 1'b0, 3};
    vecs[4]  = '{1'b0, 64'h8000_0020, 64'h0, 2'd2, 1'b1, 64'hDEADBEEFCAFEF00D, 64'hFFFFFFFFCAFEF00D, 1'b0, 3};
    vecs[5]  = '{1'b0, 64'h8000_0010, 64'h0, 2'd1, 1'b1, 64'h1111222233338001, 64'hFFFFFFFFFFFF8001, 1'b0, 3};
    vecs[6]  = '{1'b0, 64'h8000_0001, 64'h0, 2'd1, 1'b0, 64'h000000000000BEEF, 64'hBEEF, 1'b0, 3};
    vecs[7]  = '{1'b0, 64'h8000_0018, 64'h0, 2'd3, 1'b1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0, 3};
    vecs[8]  = '{1'b0, 64'h7FFF_FFFF, 64'h0, 2'd0, 1'b0, 64'hFFFF, 64'h0, 1'b1, 1};
    vecs[9]  = '{1'b0, 64'h87FF_FFFE, 64'h0, 2'd2, 1'b0, 64'hFFFF, 64'h0, 1'b1, 1};
    vecs[10] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 2'd3, 1'b0, 64'hFFFF, 64'h0, 1'b1, 1};
    vecs[11] = '{1'b1, 64'h87FF_FFFF, 64'hAB, 2'd0, 1'b0, 64'h0, 64'h0, 1'b0, 2};
    vecs[12] = '{1'b1, 64'h8000_0004, 64'hCAFEF00D, 2'd2, 1'b0, 64'h0, 64'h0, 1'b0, 2};
    vecs[13] = '{1'b1, 64'h8000_0002, 64'h1234, 2'd1, 1'b0, 64'h0, 64'h0, 1'b0, 2};
    vecs[14] = '{1'b1, 64'h87FF_FFFD, 64'h55, 2'd2, 1'b0, 64'h0, 64'h0, 1'b1, 1};
    vecs[15] = '{1'b0, 64'h87FF_FFFC, 64'h0, 2'd2, 1'b1, 64'hAAAA_AAAA_7654_3210, 64'h76543210, 1'b0, 3};

    rst = 1'b1; req_valid = 1'b0; valid2 = 1'b0; resp_ready = 1'b1;
    req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_signed = 1'b0;
    rd_pattern = '0;
    #1;
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_outputs", outs_or(), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 16; i++) do_req(vecs[i]);

    // Misaligned halfword load on the strict-alignment instance.
    @(negedge clk);
    req_wen = 1'b0; req_addr = 64'h8000_0001; req_size = 2'd1; req_signed = 1'b0;
    valid2 = 1'b1;
    chk("na_req_ready", req_ready2, 1'b1);
    @(posedge clk);
    #1 valid2 = 1'b0;
    @(negedge clk);
    chk("na_resp_valid", resp_valid2, 1'b1);
    chk("na_resp_err", resp_err2, 1'b1);
    chk("na_rd_en", rd_en2, 1'b0);
    chk("na_rdata", resp_rdata2, 64'd0);
    @(negedge clk);
    chk("na_released", resp_valid2, 1'b0);

    // Backpressure: response held while a competing request waits.
    @(negedge clk);
    req_wen = 1'b0; req_addr = 64'h8000_0020; req_size = 2'd2; req_signed = 1'b0;
    rd_pattern = 64'hDEADBEEFCAFEF00D; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    sb.push_back('{64'h00000000CAFEF00D, 1'b0});
    #1 req_wen = 1'b1; req_addr = 64'h8000_0000; req_size = 2'd3;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1;
        break;
      end
    end
    chk("bp_resp_seen", seen, 1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1'b1);
      chk("bp_rdata", resp_rdata, 64'h00000000CAFEF00D);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_strobes", {62'd0, mem_we_en, mem_rd_en}, 64'd0);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("bp_resp_rdata", resp_rdata, e.rdata);
      chk("bp_resp_err", resp_err, e.err);
    end
    resp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("bp_idle_valid", resp_valid, 1'b0);
    chk("bp_idle_ready", req_ready, 1'b1);

    // Reset asserted while the load is in WAIT.
    @(negedge clk);
    req_wen = 1'b0; req_addr = 64'h8000_0040; req_size = 2'd3; req_signed = 1'b0;
    rd_pattern = 64'h0F0E_0D0C_0B0A_0908; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", outs_or(), 64'd0);
    chk("midrst_req_ready", req_ready, 1'b1);
    sb.delete();
    @(negedge clk) rst = 1'b0;
    do_req('{1'b0, 64'h8000_0048, 64'h0, 2'd3, 1'b0, 64'h0102030405060708, 64'h0102030405060708, 1'b0, 3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
